// File: rtl/hazard_controller.sv
// hazard_controller: pipeline interlock for a 5-stage core.
// Tracks the instructions in EX and MEM, decides stall/bubble/flush/EX-hold
// from the ID instruction and the tracked stages, runs a small FSM that holds
// EX while a multi-cycle MUL completes, and registers the operand-forwarding
// selects for the instruction entering EX.
module hazard_controller #(
    parameter int REG_AW  = 3,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [7:0]        id_ctrl,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic              ex_hold,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MUL_WAIT = 2'b01
    } state_t;

    // Counter only has to hold MUL_LAT-1.
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    // EX needs load/branch info; MEM only ever acts as a forwarding source.
    // The WB result reaches EX through the write-first register file, so no
    // tag is kept for it here.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              beq;
    } ex_entry_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } mem_entry_t;

    state_t                     state_reg;
    logic [CW-1:0]              cnt_reg;
    ex_entry_t                  ex_reg;
    ex_entry_t                  ex_next;
    ex_entry_t                  id_entry;
    mem_entry_t                 mem_reg;
    mem_entry_t                 mem_next;
    logic [1:0][1:0]            fwd_reg;
    logic [1:0][1:0]            fwd_sel;
    logic [1:0][REG_AW-1:0]     id_rs;

    logic in_wait;
    logic id_mul;
    logic branch_kill;
    logic load_use;
    logic mul_enter;

    // Decode the ID control rod into a tracker entry. Stores and branches
    // never write a register even if the rod is malformed.
    always_comb begin
        id_entry          = '0;
        id_entry.valid    = id_valid;
        id_entry.rd       = id_rd;
        id_entry.regwrite = id_ctrl[6] & ~id_ctrl[5] & ~id_ctrl[3];
        id_entry.memread  = id_ctrl[4];
        id_entry.beq      = id_ctrl[3];
    end

    assign id_mul  = (id_ctrl[3:0] == 4'b0010) & ~id_ctrl[3];
    assign in_wait = (state_reg == MUL_WAIT);

    assign branch_kill = ~in_wait & ex_reg.valid & ex_reg.beq & ex_branch_taken;
    assign load_use    = id_valid & ex_reg.valid & ex_reg.memread &
                         ((ex_reg.rd == id_rs1) | (ex_reg.rd == id_rs2));

    // Hazard resolution: MUL wait dominates, then a taken branch, then
    // load-use, with JMP flushing only when the ID instruction advances.
    always_comb begin
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        ex_hold = 1'b0;
        if (in_wait) begin
            stall   = 1'b1;
            ex_hold = 1'b1;
        end else if (branch_kill) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else begin
            stall  = load_use;
            bubble = load_use;
            flush  = id_valid & id_ctrl[7] & ~load_use;
        end
    end

    // A MUL is about to be written into EX on this edge.
    assign mul_enter = ~ex_hold & ~bubble & id_valid & id_mul;

    // Next tracker contents: advance normally, or freeze EX and drain MEM.
    always_comb begin
        ex_next  = ex_reg;
        mem_next = '0;
        if (!ex_hold) begin
            ex_next  = bubble ? '0 : id_entry;
            mem_next = '{valid: ex_reg.valid, rd: ex_reg.rd, regwrite: ex_reg.regwrite};
        end
    end

    // Tracker registers for EX and MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg  <= '0;
            mem_reg <= '0;
        end else begin
            ex_reg  <= ex_next;
            mem_reg <= mem_next;
        end
    end

    // MUL sequencing FSM: enters the wait as the MUL is loaded into EX and
    // keeps EX held for MUL_LAT-1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mul_enter && (MUL_LAT > 1)) begin
                        state_reg <= MUL_WAIT;
                        cnt_reg   <= CW'(MUL_LAT - 1);
                    end
                end
                MUL_WAIT: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= RUN;
                    end
                end
                default: begin
                    state_reg <= RUN;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Forwarding selects for the ID instruction, judged against where its
    // producers will be once it reaches EX (current EX -> EX/MEM, MEM -> MEM/WB).
    assign id_rs = {id_rs2, id_rs1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                (ex_reg.valid  && ex_reg.regwrite  && (ex_reg.rd  == id_rs[gi])) ? 2'b01 :
                (mem_reg.valid && mem_reg.regwrite && (mem_reg.rd == id_rs[gi])) ? 2'b10 :
                                                                                   2'b00;
        end
    endgenerate

    // Register the selects: hold with EX, clear for a bubble, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_reg <= '0;
        end else if (ex_hold) begin
            fwd_reg <= fwd_reg;
        end else if (bubble) begin
            fwd_reg <= '0;
        end else begin
            fwd_reg <= fwd_sel;
        end
    end

    assign fwd_a = fwd_reg[0];
    assign fwd_b = fwd_reg[1];
    assign state = state_reg;

endmodule
